// File: rtl/channel_receive.sv
// -----------------------------------------------------------------------------
// channel_receive
//
// Receiving end of the memory-resident channel rendezvous protocol. One
// "receive on channel" instruction is executed per start pulse against two
// consecutive memory words:
//   channel     pid of a blocked sender, 0 when nobody is waiting
//   channel+1   that sender's message
// If no sender is waiting the receiver's pid is written into the channel cell
// and the receiver is parked. Otherwise the message is read, the channel cell
// is cleared and the waiting sender is reported for rescheduling.
// The memory port is only driven meaningfully between accept and finished.
//
// Ports
//   clk                       system clock, all state changes on rising edge
//   resetN                    asynchronous active-low reset
//   start                     level request, only sampled while idle
//   channel                   channel cell address, latched on accept
//   rxPid                     pid of the receiving process, latched on accept
//   address                   memory address (registered)
//   readWriteMode             1 = write, 0 = read (registered)
//   dataIn                    memory write data (registered)
//   dataOut                   memory read data, valid one cycle after address
//   finished                  operation complete, result outputs valid
//   shouldScheduleSender      rendezvous completed, scheduleTxPid is runnable
//   shouldDescheduleReceiver  no sender was waiting, receiver is parked
//   scheduleTxPid             pid of the sender to wake
//   receivedMessage           message taken from channel+1
// -----------------------------------------------------------------------------
module channel_receive #(
  parameter int addrBits = 8,
  parameter int dataBits = 16
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                start,
  input  logic [addrBits-1:0] channel,
  input  logic [addrBits-1:0] rxPid,
  output logic [addrBits-1:0] address,
  output logic                readWriteMode,
  output logic [dataBits-1:0] dataIn,
  input  logic [dataBits-1:0] dataOut,
  output logic                finished,
  output logic                shouldScheduleSender,
  output logic                shouldDescheduleReceiver,
  output logic [addrBits-1:0] scheduleTxPid,
  output logic [dataBits-1:0] receivedMessage
);

  typedef enum logic [2:0] {
    IDLE,
    RD_CH,
    CHECK,
    PARK,
    RD_MSG,
    GOT_MSG,
    CLEAR,
    DONE
  } stateT;

  stateT state;

  // Operands are captured at accept so later input changes cannot disturb
  // an operation in flight.
  logic [addrBits-1:0] channelReg;
  logic [addrBits-1:0] rxPidReg;

  // Single registered FSM. Every memory-port and result output is a flop so
  // the memory never sees a combinational glitch on readWriteMode.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state                    <= IDLE;
      channelReg               <= '0;
      rxPidReg                 <= '0;
      address                  <= '0;
      readWriteMode            <= 1'b0;
      dataIn                   <= '0;
      finished                 <= 1'b0;
      shouldScheduleSender     <= 1'b0;
      shouldDescheduleReceiver <= 1'b0;
      scheduleTxPid            <= '0;
      receivedMessage          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            channelReg               <= channel;
            rxPidReg                 <= rxPid;
            shouldScheduleSender     <= 1'b0;
            shouldDescheduleReceiver <= 1'b0;
            scheduleTxPid            <= '0;
            receivedMessage          <= '0;
            address                  <= channel;
            readWriteMode            <= 1'b0;
            state                    <= RD_CH;
          end
        end

        // Memory samples the channel address on this edge; the word appears
        // on dataOut for the CHECK state.
        RD_CH: begin
          state <= CHECK;
        end

        CHECK: begin
          if (dataOut == '0) begin
            address       <= channelReg;
            dataIn        <= dataBits'(rxPidReg);
            readWriteMode <= 1'b1;
            state         <= PARK;
          end else begin
            scheduleTxPid <= dataOut[addrBits-1:0];
            // Wraps modulo 2^addrBits, so the all-ones channel reads word 0.
            address       <= channelReg + addrBits'(1);
            readWriteMode <= 1'b0;
            state         <= RD_MSG;
          end
        end

        // The memory commits the receiver pid on this edge.
        PARK: begin
          readWriteMode            <= 1'b0;
          shouldDescheduleReceiver <= 1'b1;
          finished                 <= 1'b1;
          state                    <= DONE;
        end

        RD_MSG: begin
          state <= GOT_MSG;
        end

        GOT_MSG: begin
          receivedMessage <= dataOut;
          address         <= channelReg;
          dataIn          <= '0;
          readWriteMode   <= 1'b1;
          state           <= CLEAR;
        end

        // The memory clears the channel cell on this edge.
        CLEAR: begin
          readWriteMode        <= 1'b0;
          shouldScheduleSender <= 1'b1;
          finished             <= 1'b1;
          state                <= DONE;
        end

        // Holding here until start drops is what makes a long start level
        // count as a single request. Results stay valid until next accept.
        DONE: begin
          if (!start) begin
            finished <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          readWriteMode <= 1'b0;
          finished      <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel_receive.sv
// -----------------------------------------------------------------------------
// tb_channel_receive
//
// Directed bench for channel_receive with a small synchronous RAM model
// (registered read, write on readWriteMode, zero initialised). Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_channel_receive;

  localparam int addrBits = 4;
  localparam int dataBits = 8;

  logic                clk;
  logic                resetN;
  logic                start;
  logic [addrBits-1:0] channel;
  logic [addrBits-1:0] rxPid;
  logic [addrBits-1:0] address;
  logic                readWriteMode;
  logic [dataBits-1:0] dataIn;
  logic [dataBits-1:0] dataOut;
  logic                finished;
  logic                shouldScheduleSender;
  logic                shouldDescheduleReceiver;
  logic [addrBits-1:0] scheduleTxPid;
  logic [dataBits-1:0] receivedMessage;

  logic [dataBits-1:0] ram [0:(1<<addrBits)-1] = '{default: '0};
  logic                preloadEn;
  logic [addrBits-1:0] preloadAddr;
  logic [dataBits-1:0] preloadData;

  int checks = 0;
  int errors = 0;
  int cycles;
  int writes;

  channel_receive #(
    .addrBits(addrBits),
    .dataBits(dataBits)
  ) dut (
    .clk                     (clk),
    .resetN                  (resetN),
    .start                   (start),
    .channel                 (channel),
    .rxPid                   (rxPid),
    .address                 (address),
    .readWriteMode           (readWriteMode),
    .dataIn                  (dataIn),
    .dataOut                 (dataOut),
    .finished                (finished),
    .shouldScheduleSender    (shouldScheduleSender),
    .shouldDescheduleReceiver(shouldDescheduleReceiver),
    .scheduleTxPid           (scheduleTxPid),
    .receivedMessage         (receivedMessage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read data registered one cycle after the address, bench
  // preload port takes priority over DUT writes.
  always @(posedge clk) begin
    if (preloadEn) ram[preloadAddr] <= preloadData;
    else if (readWriteMode) ram[address] <= dataIn;
    dataOut <= ram[address];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic startV, input logic [addrBits-1:0] chanV,
                               input logic [addrBits-1:0] pidV);
    start   = startV;
    channel = chanV;
    rxPid   = pidV;
  endtask

  task automatic preloadWord(input logic [addrBits-1:0] a, input logic [dataBits-1:0] d);
    @(negedge clk);
    preloadEn   = 1'b1;
    preloadAddr = a;
    preloadData = d;
    @(negedge clk);
    preloadEn   = 1'b0;
  endtask

  // Counts falling edges after accept until finished is seen, bounded.
  task automatic waitFinished(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!finished && n < 50);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " address"}, 32'(address), 0);
    checkOutput({tag, " rw"}, 32'(readWriteMode), 0);
    checkOutput({tag, " dataIn"}, 32'(dataIn), 0);
    checkOutput({tag, " finished"}, 32'(finished), 0);
    checkOutput({tag, " schedSender"}, 32'(shouldScheduleSender), 0);
    checkOutput({tag, " deschedRx"}, 32'(shouldDescheduleReceiver), 0);
    checkOutput({tag, " txPid"}, 32'(scheduleTxPid), 0);
    checkOutput({tag, " message"}, 32'(receivedMessage), 0);
  endtask

  initial begin
    resetN      = 1'b0;
    preloadEn   = 1'b0;
    preloadAddr = '0;
    preloadData = '0;
    applyStimulus(1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    checkAllZero("reset");
    resetN = 1'b1;
    @(negedge clk);

    // Park: empty channel 2, receiver 12.
    preloadWord(4'd3, 8'd33);
    applyStimulus(1'b1, 4'd2, 4'd12);
    waitFinished(cycles);
    checkOutput("park latency", 32'(cycles), 4);
    checkOutput("park deschedRx", 32'(shouldDescheduleReceiver), 1);
    checkOutput("park schedSender", 32'(shouldScheduleSender), 0);
    checkOutput("park rw", 32'(readWriteMode), 0);
    checkOutput("park ram2", 32'(ram[2]), 12);
    checkOutput("park ram3", 32'(ram[3]), 33);
    start = 1'b0;
    @(negedge clk);
    checkOutput("park finished low", 32'(finished), 0);

    // Reset while in RD_MSG of a rendezvous on channel 4.
    preloadWord(4'd4, 8'd7);
    preloadWord(4'd5, 8'd42);
    applyStimulus(1'b1, 4'd4, 4'd3);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b0;
    start  = 1'b0;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    @(negedge clk);
    checkOutput("midreset ram4", 32'(ram[4]), 7);
    resetN = 1'b1;
    @(negedge clk);

    // Rendezvous rerun on channel 4.
    applyStimulus(1'b1, 4'd4, 4'd3);
    waitFinished(cycles);
    checkOutput("rdv latency", 32'(cycles), 6);
    checkOutput("rdv schedSender", 32'(shouldScheduleSender), 1);
    checkOutput("rdv deschedRx", 32'(shouldDescheduleReceiver), 0);
    checkOutput("rdv txPid", 32'(scheduleTxPid), 7);
    checkOutput("rdv message", 32'(receivedMessage), 42);
    checkOutput("rdv ram4", 32'(ram[4]), 0);
    checkOutput("rdv ram5", 32'(ram[5]), 42);
    start = 1'b0;
    @(negedge clk);
    checkOutput("rdv finished low", 32'(finished), 0);
    checkOutput("rdv held txPid", 32'(scheduleTxPid), 7);

    // Wrap: channel all-ones takes its message from address 0.
    preloadWord(4'd15, 8'd5);
    preloadWord(4'd0, 8'd99);
    applyStimulus(1'b1, 4'd15, 4'd1);
    waitFinished(cycles);
    checkOutput("wrap latency", 32'(cycles), 6);
    checkOutput("wrap txPid", 32'(scheduleTxPid), 5);
    checkOutput("wrap message", 32'(receivedMessage), 99);
    checkOutput("wrap ram15", 32'(ram[15]), 0);
    checkOutput("wrap ram0", 32'(ram[0]), 99);
    start = 1'b0;
    @(negedge clk);

    // Held start: one park on channel 6 over 20 cycles of start high.
    applyStimulus(1'b1, 4'd6, 4'd9);
    writes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (readWriteMode) writes++;
    end
    checkOutput("held writes", 32'(writes), 1);
    checkOutput("held finished", 32'(finished), 1);
    checkOutput("held deschedRx", 32'(shouldDescheduleReceiver), 1);
    checkOutput("held ram6", 32'(ram[6]), 9);
    start = 1'b0;
    @(negedge clk);
    checkOutput("held finished low", 32'(finished), 0);

    // Busy start: inputs wiggle during RD_CH..CLEAR of a rendezvous on 8.
    preloadWord(4'd8, 8'd11);
    preloadWord(4'd9, 8'd77);
    applyStimulus(1'b1, 4'd8, 4'd2);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      applyStimulus((k % 2 == 0) || (k == 5), 4'(10 + k), 4'(k));
    end
    @(negedge clk);
    checkOutput("busy finished", 32'(finished), 1);
    checkOutput("busy schedSender", 32'(shouldScheduleSender), 1);
    checkOutput("busy txPid", 32'(scheduleTxPid), 11);
    checkOutput("busy message", 32'(receivedMessage), 77);
    checkOutput("busy ram8", 32'(ram[8]), 0);
    checkOutput("busy ram13", 32'(ram[13]), 0);
    start = 1'b0;
    @(negedge clk);
    checkOutput("busy finished low", 32'(finished), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
